// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, access
// encodings, interrupt cause codes and status/enable bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        ACC_READ  = 2'b00,
        ACC_WRITE = 2'b01,
        ACC_SET   = 2'b10,
        ACC_CLEAR = 2'b11
    } access_e;

    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Value a write-type access would store, given the current contents.
    function automatic logic [31:0] csr_next(
        input access_e     acc,
        input logic [31:0] cur,
        input logic [31:0] op
    );
        logic [31:0] r;
        r = cur;
        case (acc)
            ACC_WRITE: r = op;
            ACC_SET:   r = cur | op;
            ACC_CLEAR: r = cur & ~op;
            default:   r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csr_file_m_counter.sv
// csr_counter: wrapping performance counter, WIDTH bits (32..64), exposed
// as a 64-bit value with bits >= WIDTH reading 0; each 32-bit half is
// writable and a write suppresses the increment that cycle.
// Ports: clk, reset, inc, wr_lo, wr_hi, wdata[31:0], value[63:0].
module csr_counter
    import csr_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [WIDTH-1:0] count;
    logic [63:0]      nxt;

    assign value = 64'(count);

    // Truncation to WIDTH bits gives the wrap to 0 for free.
    always_comb begin
        nxt = value;
        if (wr_lo) begin
            nxt[31:0] = wdata;
        end else if (wr_hi) begin
            nxt[63:32] = wdata;
        end else if (inc) begin
            nxt = value + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= nxt[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with trap entry/return, prioritised
// interrupts, illegal-access detection and mcycle/minstret counters.
// Ports: clk, reset, number/access_type/in -> out/illegal (CSR access);
// external/timer/software_interrupt, exception(+cause,tval), exit_trap,
// retire, current_pc -> next_pc, trap.
// Optional: CSR_VECTORED_EN enables writable mtvec.MODE and vectored
// interrupt dispatch.
module csr_file_m
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID       = 32'd0,
    parameter int          COUNTER_WIDTH = 64,
    parameter logic [31:0] MISA_EXT      = 32'h00000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] number,
    input  logic [1:0]  access_type,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        illegal,
    input  logic        external_interrupt,
    input  logic        timer_interrupt,
    input  logic        software_interrupt,
    input  logic        exception,
    input  logic [3:0]  exception_cause,
    input  logic [31:0] exception_tval,
    input  logic        exit_trap,
    input  logic        retire,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        trap
);

    logic        st_mie;
    logic        st_mpie;
    logic        en_meie;
    logic        en_mtie;
    logic        en_msie;
    logic [29:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mscratch;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] rdata;
    logic        impl;
    logic [31:0] wdata;
    logic        wr_en;
    logic        pend_e;
    logic        pend_s;
    logic        pend_t;
    logic [3:0]  irq_code;
    logic [31:0] trap_target;
    access_e     acc;

    assign acc = access_e'(access_type);

    always_comb begin
        rdata = 32'd0;
        impl  = 1'b1;
        case (number)
            CSR_MSTATUS:   rdata = {19'd0, 2'b11, 3'd0, st_mpie,
                                    3'd0, st_mie, 3'd0};
            CSR_MISA:      rdata = {2'b01, 30'd0} | MISA_EXT;
            CSR_MIE:       rdata = {20'd0, en_meie, 3'd0, en_mtie,
                                    3'd0, en_msie, 3'd0};
            CSR_MTVEC:     rdata = {mtvec_base, mtvec_mode};
            CSR_MSCRATCH:  rdata = mscratch;
            CSR_MEPC:      rdata = mepc;
            CSR_MCAUSE:    rdata = mcause;
            CSR_MTVAL:     rdata = mtval;
            CSR_MIP:       rdata = {20'd0, external_interrupt, 3'd0,
                                    timer_interrupt, 3'd0,
                                    software_interrupt, 3'd0};
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MVENDORID: rdata = 32'd0;
            CSR_MARCHID:   rdata = 32'd0;
            CSR_MIMPID:    rdata = 32'd0;
            CSR_MHARTID:   rdata = HART_ID;
            default:       impl  = 1'b0;
        endcase
    end

    assign illegal = !impl
                  || (number[11:10] == 2'b11 && acc != ACC_READ);
    assign out     = illegal ? 32'd0 : rdata;
    assign wdata   = csr_next(acc, rdata, in);

    assign pend_e = external_interrupt & en_meie & st_mie;
    assign pend_s = software_interrupt & en_msie & st_mie;
    assign pend_t = timer_interrupt    & en_mtie & st_mie;
    assign trap   = exception | pend_e | pend_s | pend_t;

    always_comb begin
        if (pend_e) begin
            irq_code = IRQ_CODE_MEI;
        end else if (pend_s) begin
            irq_code = IRQ_CODE_MSI;
        end else begin
            irq_code = IRQ_CODE_MTI;
        end
    end

    // Trap entry and mret both take the cycle; the CSR write loses.
    assign wr_en = acc != ACC_READ && !illegal && !trap && !exit_trap;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            en_meie    <= 1'b0;
            en_mtie    <= 1'b0;
            en_msie    <= 1'b0;
            mtvec_base <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
            mscratch   <= '0;
        end else if (trap) begin
            mepc    <= current_pc & ~32'h3;
            mcause  <= exception ? {28'd0, exception_cause}
                                 : {1'b1, 27'd0, irq_code};
            mtval   <= exception ? exception_tval : 32'd0;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (exit_trap) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_en) begin
            case (number)
                CSR_MSTATUS: begin
                    st_mie  <= wdata[MSTATUS_MIE];
                    st_mpie <= wdata[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    en_meie <= wdata[MIE_MEIE];
                    en_mtie <= wdata[MIE_MTIE];
                    en_msie <= wdata[MIE_MSIE];
                end
                CSR_MTVEC:    mtvec_base <= wdata[31:2];
                CSR_MSCRATCH: mscratch   <= wdata;
                CSR_MEPC:     mepc       <= wdata & ~32'h3;
                CSR_MCAUSE:   mcause     <= wdata;
                CSR_MTVAL:    mtval      <= wdata;
                default: ;
            endcase
        end
    end

`ifdef CSR_VECTORED_EN
    // Reserved modes 10/11 are not stored; the previous mode stays.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec_mode <= MTVEC_DIRECT;
        end else if (wr_en && number == CSR_MTVEC && !wdata[1]) begin
            mtvec_mode <= wdata[1:0];
        end
    end

    always_comb begin
        trap_target = {mtvec_base, 2'b00};
        if (mtvec_mode == MTVEC_VECTORED && !exception) begin
            trap_target = {mtvec_base, 2'b00}
                        + {26'd0, irq_code, 2'b00};
        end
    end
`else
    assign mtvec_mode  = MTVEC_DIRECT;
    assign trap_target = {mtvec_base, 2'b00};
`endif

    always_comb begin
        next_pc = 32'd0;
        if (reset) begin
            next_pc = 32'd0;
        end else if (trap) begin
            next_pc = trap_target;
        end else if (exit_trap) begin
            next_pc = mepc;
        end
    end

    csr_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) u_mcycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (wr_en && number == CSR_MCYCLE),
        .wr_hi (wr_en && number == CSR_MCYCLEH),
        .wdata (wdata),
        .value (mcycle)
    );

    csr_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) u_minstret (
        .clk   (clk),
        .reset (reset),
        .inc   (retire && !trap),
        .wr_lo (wr_en && number == CSR_MINSTRET),
        .wr_hi (wr_en && number == CSR_MINSTRETH),
        .wdata (wdata),
        .value (minstret)
    );

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
Parametrised machine-mode CSR file for the single-issue RV32 core, sitting beside the decode/execute stage.
- Adds over the previous generation: mscratch, mcause, mtval and mip; prioritised interrupt cause encoding; optional vectored trap dispatch; illegal-access detection; mcycle/minstret performance counters of configurable width.
- The core issues at most one CSR access per cycle. Trap and return redirection happens in the same cycle it is requested.

Parameters:
- HART_ID, 0, value returned by mhartid.
- COUNTER_WIDTH, 64, width of mcycle/minstret, legal 32..64. Bits at and above COUNTER_WIDTH read as 0.
- MISA_EXT, 32'h00000100, extension bits ORed into misa. misa[31:30] are fixed at 2'b01.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- number  in  12  CSR address
- access_type  in  2  READ_ONLY=00, WRITE=01, SET=10, CLEAR=11
- in  in  32  write/set/clear operand
- out  out  32  current value of the addressed CSR (combinational)
- illegal  out  1  access to an unimplemented CSR, or write-type access to a read-only CSR
- external_interrupt  in  1  level MEIP
- timer_interrupt  in  1  level MTIP
- software_interrupt  in  1  level MSIP
- exception  in  1  synchronous exception this cycle
- exception_cause  in  4  mcause code for the exception
- exception_tval  in  32  value for mtval
- exit_trap  in  1  mret executing
- retire  in  1  one instruction retires this cycle
- current_pc  in  32  pc of the instruction in execute
- next_pc  out  32  redirect target
- trap  out  1  trap taken this cycle

Behaviour:
- Reset values:
  - All writable state resets to 0: mtvec, mepc, mcause, mtval, mscratch, mie bits, mstatus.MIE, mstatus.MPIE, counters.
  - Outputs while reset is high: trap and illegal follow their combinational definitions. next_pc=0.
- Register layouts:
  - mstatus: MIE bit 3, MPIE bit 7, MPP [12:11] hardwired to 2'b11, all other bits 0.
  - mie: MEIE bit 11, MTIE bit 7, MSIE bit 3.
  - mip: read-only; bits 11/7/3 reflect the interrupt inputs directly.
  - mepc: bits [1:0] forced to 0.
  - mtvec: BASE [31:2], MODE [1:0].
  - mvendorid, marchid, mimpid read 0. mhartid reads HART_ID.
- Write operand (next): WRITE gives in; SET gives out|in; CLEAR gives out&~in. Any access_type other than READ_ONLY is a write, even when in=0.
- illegal=1 when number is unimplemented, or when number[11:10]=2'b11 and access_type≠READ_ONLY. An illegal access never changes state; out=0.
- Interrupt pending: pend_x = input_x & mie_x & mstatus.MIE.
  - Priority: external, then software, then timer.
  - trap = exception | any pend_x.
  - An exception beats all interrupts.
- Trap entry, registered at the clock edge after trap=1:
  - mepc <= current_pc.
  - mcause <= exception ? {1'b0,27'b0,exception_cause} : {1'b1,27'b0,code}, code=11/3/7 for external/software/timer.
  - mtval <= exception ? exception_tval : 0.
  - MPIE <= MIE; MIE <= 0.
- exit_trap (ignored when trap=1): MIE <= MPIE; MPIE <= 1.
- Same-cycle priority for state updates: trap, then exit_trap, then CSR write. A CSR write in a trap or exit_trap cycle is dropped.
- next_pc (combinational):
  - trap: {mtvec.BASE,2'b00}.
  - exit_trap: mepc.
  - Otherwise 0.
- Counters:
  - mcycle increments every cycle reset is low.
  - minstret increments when retire=1 and trap=0.
  - Both wrap to 0 after 2^COUNTER_WIDTH-1.
  - mcycle/mcycleh and minstret/minstreth expose bits [31:0] / [63:32].
  - A CSR write to either half replaces that half and suppresses that counter's increment in that cycle. The other half holds.

Optional Feature:
- CSR_VECTORED_EN defined:
  - mtvec.MODE is writable. Writing 00 or 01 stores it; writing 10 or 11 leaves MODE unchanged.
  - When MODE=01 and the trap is an interrupt, next_pc = BASE + 4*code.
  - Exceptions always go to BASE.
- Undefined: MODE is hardwired to 00 and reads as 00; dispatch is always to BASE.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants, including mscratch 0x340, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
  - access_type enum.
  - Interrupt cause codes.
  - mstatus/mie bit positions.
- Sub-module csr_counter (parameter WIDTH; ports inc, wr_lo, wr_hi, wdata, value). Instantiated twice.

Test Plan:
- Reset, then read misa / mhartid (HART_ID=3) / mstatus -> 0x40000100 / 3 / 0x00001800. illegal=0.
- WRITE mtvec=0x100; SET mie=0x880; SET mstatus=0x8; raise timer_interrupt -> trap=1, next_pc=0x100. Next cycle: mcause=0x80000007, mepc=current_pc, mstatus=0x1880.
- Assert timer, software and external together with exception=1, cause=2, tval=0xDEAD -> mcause=0x2, mtval=0xDEAD. Then exit_trap -> next_pc=mepc, mstatus.MIE=1, MPIE=1.
- WRITE mhartid, or read number 0x7C0 -> illegal=1, no register changes.
- COUNTER_WIDTH=64: WRITE mcycle=0xFFFFFFFF, mcycleh=0 on separate cycles -> mcycleh reads 1 two cycles after the low write. retire held 5 cycles with one trap cycle inside -> minstret +4.
- CSR_VECTORED_EN: mtvec=0x201, external interrupt -> next_pc=0x22C. Exception -> next_pc=0x200. Write MODE=2 -> MODE stays 01.
